// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: duty width/limit, ramp states and the
// valid/ready fire condition used by every stage on the duty path.
`ifndef PWM_HS_FIRE
`define PWM_HS_FIRE(valid, ready) ((valid) && (ready))
`endif

package pwm_pkg;

  localparam int unsigned DUTY_W   = 7;
  localparam int unsigned DUTY_MAX = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// Period-tick divider: counts tick_i pulses and fires upd_o on the tick that
// brings the count to rate_i, restarting from zero at that same edge.
module pwm_tick_div #(
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              upd_o
);

  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [RATE_W:0]   cnt_inc;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (RATE_W + 1)'(1);
    cnt_d   = cnt_q;
    upd_o   = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc == {1'b0, rate_i}) begin
        cnt_d = '0;
        upd_o = 1'b1;
      end else begin
        cnt_d = cnt_inc[RATE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate-limited duty command: steps duty_o toward an accepted target only on
// divided PWM period ticks, with emergency stop to zero.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tgt_valid_i,
  output logic              tgt_ready_o,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              period_tick_i,
  input  logic              stop_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned SumW = DUTY_W + 1;
  localparam logic [DUTY_W-1:0] DutyMaxC = DUTY_W'(DUTY_MAX);

  pwm_state_e        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              done_q, done_d;

  logic              accept;
  logic              upd;
  logic [DUTY_W-1:0] tgt_clamped;
  logic [SumW-1:0]   up_sum;
  logic [DUTY_W-1:0] up_val, dn_val;

  assign tgt_ready_o = (state_q == ST_IDLE) && !stop_i;
  assign accept      = `PWM_HS_FIRE(tgt_valid_i, tgt_ready_o);
  assign tgt_clamped = (tgt_duty_i > DutyMaxC) ? DutyMaxC : tgt_duty_i;

  // Counter idles at zero so a fresh ramp always waits a full rate of ticks.
  pwm_tick_div #(
    .RATE_W (RATE_W)
  ) u_tick_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (stop_i || (state_q == ST_IDLE)),
    .tick_i  (period_tick_i),
    .rate_i  (rate_q),
    .upd_o   (upd)
  );

  // One spare bit keeps the approach to the target free of wrap in both directions.
  assign up_sum = {1'b0, duty_q} + SumW'(step_q);
  assign up_val = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[DUTY_W-1:0];
  assign dn_val = ({1'b0, duty_q} < ({1'b0, tgt_q} + SumW'(step_q))) ? tgt_q
                : (duty_q - DUTY_W'(step_q));

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    rate_d  = rate_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tgt_d  = tgt_clamped;
            step_d = (step_i == '0) ? STEP_W'(1) : step_i;
            rate_d = (rate_i == '0) ? RATE_W'(1) : rate_i;
            if (tgt_clamped > duty_q) begin
              state_d = ST_UP;
            end else if (tgt_clamped < duty_q) begin
              state_d = ST_DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_UP, ST_DOWN: begin
          if (upd) begin
            duty_d = (state_q == ST_UP) ? up_val : dn_val;
            if (duty_d == tgt_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= STEP_W'(1);
      rate_q  <= RATE_W'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      rate_q  <= rate_d;
      done_q  <= done_d;
    end
  end

  assign duty_o = duty_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios with literal expectations, then
// random stimulus, all outputs compared every cycle against a behavioural model.
module tb_pwm_duty_ramp;

  logic       clk;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [6:0] tgt_duty;
  logic [3:0] step;
  logic [7:0] rate;
  logic       tick;
  logic       stop;
  logic [6:0] duty;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  pwm_duty_ramp dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tgt_valid_i   (tgt_valid),
    .tgt_ready_o   (tgt_ready),
    .tgt_duty_i    (tgt_duty),
    .step_i        (step),
    .rate_i        (rate),
    .period_tick_i (tick),
    .stop_i        (stop),
    .duty_o        (duty),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers, direction taken from target vs duty.
  int m_duty, m_tgt, m_step, m_rate, m_ticks;
  bit m_busy, m_done, started;

  always @(posedge clk) begin
    if (rst) begin
      m_duty = 0; m_tgt = 0; m_step = 1; m_rate = 1; m_ticks = 0;
      m_busy = 0; m_done = 0; started = 1;
    end else begin
      m_done = 0;
      if (stop) begin
        m_duty = 0; m_busy = 0; m_ticks = 0;
      end else if (!m_busy) begin
        if (tgt_valid) begin
          m_tgt   = (int'(tgt_duty) > 100) ? 100 : int'(tgt_duty);
          m_step  = (step == 0) ? 1 : int'(step);
          m_rate  = (rate == 0) ? 1 : int'(rate);
          m_ticks = 0;
          if (m_tgt == m_duty) m_done = 1;
          else m_busy = 1;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks >= m_rate) begin
          m_ticks = 0;
          if (m_tgt > m_duty) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
          else m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
          if (m_duty == m_tgt) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_duty", int'(duty), m_duty);
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
      chk("model_ready", int'(tgt_ready), int'(!m_busy && !stop));
    end
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
  endtask

  task automatic offer(input int t, input int s, input int r);
    tgt_valid = 1'b1;
    tgt_duty  = 7'(t);
    step      = 4'(s);
    rate      = 8'(r);
    clk_step();
    tgt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_duty = '0; step = '0; rate = '0;
    tick = 1'b0; stop = 1'b0;

    // Reset
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset_duty", int'(duty), 0);
    chk("reset_ready", int'(tgt_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    // Ramp up 0 -> 40, step 10, rate 1
    offer(40, 10, 1);
    chk("up_busy", int'(busy), 1);
    for (int k = 1; k <= 4; k++) begin
      tick_pulse();
      chk($sformatf("up_tick%0d", k), int'(duty), 10 * k);
      if (k < 4) idle(7);
    end
    chk("up_done", int'(done), 1);
    chk("up_ready", int'(tgt_ready), 1);
    idle(1);
    chk("up_done_once", int'(done), 0);

    // Ramp down 40 -> 5 with clamp at the target
    offer(5, 10, 1);
    for (int k = 1; k <= 4; k++) begin
      tick_pulse();
      chk($sformatf("dn_tick%0d", k), int'(duty), (k < 4) ? 40 - 10 * k : 5);
      idle(7);
    end
    chk("dn_idle", int'(busy), 0);

    // Sanitising: target 120 -> 100, step 0 -> 1, rate 3
    offer(120, 0, 3);
    for (int k = 1; k <= 6; k++) begin
      tick_pulse();
      chk($sformatf("san_tick%0d", k), int'(duty), 5 + k / 3);
      idle(7);
    end
    chk("san_busy", int'(busy), 1);
    stop = 1'b1;
    #1;
    chk("stop_ready", int'(tgt_ready), 0);
    clk_step();
    stop = 1'b0;
    chk("stop_duty", int'(duty), 0);
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      idle(2);
    end
    chk("idle_tick_hold0", int'(duty), 0);

    // Stop mid-ramp at 30 with a target held
    offer(50, 10, 1);
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      idle(3);
    end
    chk("pre_stop_duty", int'(duty), 30);
    tgt_valid = 1'b1; tgt_duty = 7'd20; step = 4'd10; rate = 8'd1; stop = 1'b1;
    clk_step();
    chk("stop2_duty", int'(duty), 0);
    chk("stop2_busy", int'(busy), 0);
    chk("stop2_done", int'(done), 0);
    clk_step();
    chk("stop2_hold_busy", int'(busy), 0);
    stop = 1'b0;
    clk_step();
    tgt_valid = 1'b0;
    chk("post_stop_accept", int'(busy), 1);
    tick_pulse();
    chk("post_stop_t1", int'(duty), 10);
    idle(3);
    tick_pulse();
    chk("post_stop_t2", int'(duty), 20);
    chk("post_stop_done", int'(done), 1);
    for (int k = 0; k < 2; k++) begin
      tick_pulse();
      idle(2);
    end
    chk("idle_tick_hold20", int'(duty), 20);

    // Equal target
    offer(20, 3, 1);
    chk("eq_busy", int'(busy), 0);
    chk("eq_done", int'(done), 1);
    idle(1);
    chk("eq_done_once", int'(done), 0);

    // Reset during UP
    offer(80, 5, 1);
    tick_pulse();
    tick_pulse();
    chk("rst_pre_duty", int'(duty), 30);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(tgt_ready), 1);

    // Random phase, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      tgt_valid = ($urandom_range(0, 3) == 0);
      tgt_duty  = 7'($urandom_range(0, 127));
      step      = 4'($urandom_range(0, 15));
      rate      = 8'($urandom_range(0, 3));
      tick      = ($urandom_range(0, 2) == 0);
      stop      = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      clk_step();
    end
    tgt_valid = 1'b0; tick = 1'b0; stop = 1'b0; rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
